// File: rtl/root_operation_pkg.sv
// rtl/root_operation_pkg.sv - shared state encoding and sizing helpers for the integer root engine
package root_operation_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SET_BIT = 3'd2,
        POW     = 3'd3,
        CMP     = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Number of result bits searched: the k-th root (k>=2) of a W-bit value fits in W/2 bits.
    function automatic int calc_rb(input int data_width);
        return data_width / 2;
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/root_power_step.sv
// rtl/root_power_step.sv - one saturating multiply step of the candidate power loop
module root_power_step #(
    parameter int DATA_WIDTH = 32,
    parameter int RB         = 16
) (
    input  logic [RB-1:0]         i_cand,
    input  logic [DATA_WIDTH-1:0] i_prod,
    input  logic                  i_sat,
    output logic [DATA_WIDTH-1:0] o_prod,
    output logic                  o_sat
);

    logic [2*DATA_WIDTH-1:0] w_p;
    logic                    w_ovf;

    assign w_p   = (2*DATA_WIDTH)'(i_prod) * (2*DATA_WIDTH)'(i_cand);
    assign w_ovf = |w_p[2*DATA_WIDTH-1:DATA_WIDTH];

    // Once saturated the product is frozen, so it can never wrap back below the radicand.
    assign o_sat  = i_sat | w_ovf;
    assign o_prod = o_sat ? i_prod : w_p[DATA_WIDTH-1:0];

endmodule

// File: rtl/integer_root_operation.sv
// rtl/integer_root_operation.sv - unsigned floor k-th root by bit-serial binary search
// Define ROOT_EXACT_EN to add the out_exact port and its equality tracking.
module integer_root_operation
    import root_operation_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROOT_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] inp_value,
    input  logic [ROOT_WIDTH-1:0] inp_root,
    output logic                  busy,
    output logic                  output_ready,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic                  error
`ifdef ROOT_EXACT_EN
    ,
    output logic                  out_exact
`endif
);

    localparam int RB = calc_rb(DATA_WIDTH);
    localparam int BW = index_width(RB);

    state_t                r_state;
    state_t                w_next;

    logic [DATA_WIDTH-1:0] r_value;
    logic [ROOT_WIDTH-1:0] r_root;
    logic [DATA_WIDTH-1:0] r_result;
    logic [RB-1:0]         r_cand;
    logic [DATA_WIDTH-1:0] r_prod;
    logic                  r_sat;
    logic [ROOT_WIDTH-1:0] r_cnt;
    logic [BW-1:0]         r_bit;
    logic                  r_err;
    logic                  r_output_ready;
    logic [DATA_WIDTH-1:0] r_out_value;
    logic                  r_error;

    logic [RB-1:0]         w_cand;
    logic [DATA_WIDTH-1:0] w_prod_next;
    logic                  w_sat_next;
    logic                  w_accept;
    logic                  w_degenerate;

    assign w_cand       = r_result[RB-1:0] | (RB'(1) << r_bit);
    assign w_accept     = !r_sat && (r_prod <= r_value);
    assign w_degenerate = (r_root == ROOT_WIDTH'(0)) || (r_root == ROOT_WIDTH'(1));

    root_power_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .RB         (RB)
    ) u_power_step (
        .i_cand (r_cand),
        .i_prod (r_prod),
        .i_sat  (r_sat),
        .o_prod (w_prod_next),
        .o_sat  (w_sat_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = INIT;
            INIT:    w_next = w_degenerate ? DONE : SET_BIT;
            SET_BIT: w_next = POW;
            // Counter was loaded with k-1, so the step taken at count 1 is the last multiply.
            POW:     if (r_cnt == ROOT_WIDTH'(1)) w_next = CMP;
            CMP:     w_next = (r_bit == BW'(0)) ? DONE : SET_BIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_value        <= '0;
            r_root         <= '0;
            r_result       <= '0;
            r_cand         <= '0;
            r_prod         <= '0;
            r_sat          <= 1'b0;
            r_cnt          <= '0;
            r_bit          <= '0;
            r_err          <= 1'b0;
            r_output_ready <= 1'b0;
            r_out_value    <= '0;
            r_error        <= 1'b0;
        end else begin
            r_output_ready <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    r_value <= inp_value;
                    r_root  <= inp_root;
                end
                INIT: begin
                    r_bit    <= BW'(RB - 1);
                    r_err    <= (r_root == ROOT_WIDTH'(0));
                    r_result <= (r_root == ROOT_WIDTH'(1)) ? r_value : '0;
                end
                SET_BIT: begin
                    r_cand <= w_cand;
                    r_prod <= DATA_WIDTH'(w_cand);
                    r_sat  <= 1'b0;
                    r_cnt  <= r_root - ROOT_WIDTH'(1);
                end
                POW: begin
                    r_prod <= w_prod_next;
                    r_sat  <= w_sat_next;
                    r_cnt  <= r_cnt - ROOT_WIDTH'(1);
                end
                CMP: begin
                    if (w_accept) r_result <= DATA_WIDTH'(r_cand);
                    if (r_bit != BW'(0)) r_bit <= r_bit - BW'(1);
                end
                DONE: begin
                    r_out_value <= r_result;
                    r_error     <= r_err;
                end
                default: ;
            endcase
        end
    end

`ifdef ROOT_EXACT_EN
    logic r_exact;
    logic r_out_exact;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_exact     <= 1'b0;
            r_out_exact <= 1'b0;
        end else begin
            case (r_state)
                INIT:    r_exact <= (r_value == '0) || (r_root == ROOT_WIDTH'(1));
                CMP:     if (w_accept && (r_prod == r_value)) r_exact <= 1'b1;
                DONE:    r_out_exact <= r_exact && !r_err;
                default: ;
            endcase
        end
    end

    assign out_exact = r_out_exact;
`endif

    assign busy         = (r_state != IDLE);
    assign output_ready = r_output_ready;
    assign out_value    = r_out_value;
    assign error        = r_error;

endmodule

// File: tb/tb_integer_root_operation.sv
// tb/tb_integer_root_operation.sv - directed bench with an arithmetic reference model for integer_root_operation
module tb_integer_root_operation;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] inp_value = '0;
    logic [2:0]  inp_root = '0;
    logic        busy;
    logic        output_ready;
    logic [31:0] out_value;
    logic        error;
`ifdef ROOT_EXACT_EN
    logic        out_exact;
`endif

    integer_root_operation #(
        .DATA_WIDTH (32),
        .ROOT_WIDTH (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .inp_value    (inp_value),
        .inp_root     (inp_root),
        .busy         (busy),
        .output_ready (output_ready),
        .out_value    (out_value),
        .error        (error)
`ifdef ROOT_EXACT_EN
        ,
        .out_exact    (out_exact)
`endif
    );

    always #5 clock = ~clock;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic rst_q  = 1'b1;

    // One outstanding request as seen by the model
    logic        pend  = 1'b0;
    int          p_acc = 0;
    int          p_lat = 0;
    logic [31:0] p_val = '0;
    logic        p_err = 1'b0;
    logic        p_ex  = 1'b0;
    logic [31:0] exp_out = '0;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // r^k, or cap+1 as soon as it exceeds cap
    function automatic longint mpow(input longint r, input int k, input longint cap);
        longint p = 1;
        for (int i = 0; i < k; i++) begin
            p = p * r;
            if (p > cap) return cap + 1;
        end
        return p;
    endfunction

    function automatic longint mroot(input longint v, input int k);
        longint lo = 0;
        longint hi = 65535;
        longint mid;
        if (k == 0) return 0;
        if (k == 1) return v;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mpow(mid, k, v) <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic mexact(input longint v, input int k);
        if (k == 0) return 1'b0;
        if (k == 1) return 1'b1;
        return mpow(mroot(v, k), k, v) == v;
    endfunction

    function automatic int mlat(input int k);
        return (k < 2) ? 2 : 2 + 16 * (k + 1);
    endfunction

    always @(negedge clock) begin
        logic exp_rdy;
        logic exp_busy;
        if (rst_q) begin
            pend    = 1'b0;
            exp_out = '0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ready", 32'(output_ready), 32'd0);
            check("rst_error", 32'(error), 32'd0);
            check("rst_out_value", out_value, 32'd0);
`ifdef ROOT_EXACT_EN
            check("rst_out_exact", 32'(out_exact), 32'd0);
`endif
        end else begin
            exp_rdy  = pend && (cyc == p_acc + p_lat);
            exp_busy = pend && (cyc >= p_acc) && (cyc < p_acc + p_lat);
            check("busy", 32'(busy), 32'(exp_busy));
            check("output_ready", 32'(output_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                exp_out = p_val;
                pend    = 1'b0;
                check("error", 32'(error), 32'(p_err));
`ifdef ROOT_EXACT_EN
                check("out_exact", 32'(out_exact), 32'(p_ex));
`endif
            end
            check("out_value", out_value, exp_out);
        end
    end

    task automatic start_op(input logic [31:0] v, input int k);
        @(negedge clock);
        inp_value = v;
        inp_root  = k[2:0];
        start     = 1'b1;
        p_val     = 32'(mroot(v, k));
        p_err     = (k == 0);
        p_ex      = mexact(v, k);
        p_lat     = mlat(k);
        p_acc     = cyc + 1;
        pend      = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        inp_value = $urandom;
        inp_root  = 3'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (pend && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (pend) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no completion after %0d cycles", nm, n);
            pend = 1'b0;
        end
    endtask

    task automatic run_op(input logic [31:0] v, input int k, input logic [31:0] lit, input string nm);
        start_op(v, k);
        wait_done(nm);
        check({nm, "_literal"}, out_value, lit);
    endtask

    initial begin
        check("model_sqrt", 32'(mroot(1000000, 2)), 32'd1000);
        check("model_cbrt", 32'(mroot(30, 3)), 32'd3);
        check("model_sat7", 32'(mroot(64'hFFFFFFFF, 7)), 32'd23);
        check("model_zero", 32'(mroot(0, 5)), 32'd0);
        check("model_k1", 32'(mroot(64'hDEADBEEF, 1)), 32'hDEADBEEF);
        check("model_exact_sqrt", 32'(mexact(1000000, 2)), 32'd1);
        check("model_exact_cbrt", 32'(mexact(30, 3)), 32'd0);
        check("model_lat2", 32'(mlat(2)), 32'd50);
        check("model_lat3", 32'(mlat(3)), 32'd66);

        repeat (3) @(negedge clock);
        reset = 1'b0;

        run_op(32'd1000000,  2, 32'd1000,       "sqrt");
        run_op(32'd30,       3, 32'd3,          "cbrt30");
        run_op(32'hFFFFFFFF, 7, 32'd23,         "sat7");
        run_op(32'hDEADBEEF, 1, 32'hDEADBEEF,   "k1");
        run_op(32'h12345678, 0, 32'd0,          "k0");
        run_op(32'd0,        5, 32'd0,          "zero5");
        run_op(32'hFFFFFFFF, 2, 32'd65535,      "sqrt_max");
        run_op(32'd81,       4, 32'd3,          "root4");
        run_op(32'd64,       6, 32'd2,          "root6");
        run_op(32'd127,      7, 32'd1,          "root7_below");
        run_op(32'd0,        0, 32'd0,          "k0_zero");

        // A second start during the search must be ignored
        start_op(32'd1000, 3);
        repeat (10) @(negedge clock);
        inp_value = 32'd5;
        inp_root  = 3'd2;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        wait_done("ignored_start");
        check("ignored_start_literal", out_value, 32'd10);

        // Abort a square root mid-search; nothing may complete afterwards
        start_op(32'd1000000, 2);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (80) @(negedge clock);
        run_op(32'd1000000, 2, 32'd1000, "after_reset");

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/integer_root_operation.md
Name: integer_root_operation

Overview:
- Computes the unsigned integer k-th root, out_value = floor(inp_value^(1/inp_root)). This is the inverse of the exponent engine.
- Uses a bit-serial binary search. Each candidate bit is checked by raising the candidate to the k-th power with a repeated-multiply loop.
- Uses the same start / output_ready handshake as the other arithmetic engines, so the crypto datapath sequencer can drive it interchangeably.

Parameters:
- DATA_WIDTH, 32, width of inp_value and out_value; must be even.
- ROOT_WIDTH, 3, width of the root degree k; legal k is 1..2^ROOT_WIDTH-1.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- inp_value  input  DATA_WIDTH  radicand, unsigned
- inp_root  input  ROOT_WIDTH  root degree k, unsigned
- busy  output  1  high from the cycle after start is accepted until output_ready
- output_ready  output  1  one-cycle completion pulse
- out_value  output  DATA_WIDTH  root result; held until the next completion
- error  output  1  valid with output_ready; high when k==0
- out_exact  output  1  valid with output_ready; high when out_value^k == inp_value (present only with ROOT_EXACT_EN)

Behaviour:
- Reset: state=IDLE; busy=0, output_ready=0, out_value=0, error=0, out_exact=0. Reset mid-operation aborts the search; no output_ready follows.
- Localparam RB = DATA_WIDTH/2. The search covers result bits RB-1 down to 0.
- IDLE:
  - Latches inp_value and inp_root every cycle; output_ready=0.
  - start=1 -> INIT.
- INIT:
  - busy=1; result=0; bit index=RB-1.
  - k==0 -> DONE with error=1, result=0.
  - k==1 -> DONE with result=value.
  - Otherwise -> SET_BIT.
- SET_BIT:
  - cand = result | (1<<bit); prod = cand; sat = 0; loop count = k-1 -> POW.
- POW (k-1 cycles, one multiply per cycle):
  - p = prod*cand computed at 2*DATA_WIDTH width.
  - If sat is set, or the upper DATA_WIDTH bits of p are non-zero, sat <= 1 and prod is held.
  - Otherwise prod <= lower half of p.
  - Loop count 0 -> CMP.
- CMP:
  - If !sat and prod <= value, result <= cand.
  - If bit==0 -> DONE; else bit-1 -> SET_BIT.
- DONE:
  - out_value <= result; output_ready=1 for exactly one cycle; busy=0 -> IDLE.
- Latency, counted in cycles from the edge that samples start to output_ready high:
  - k>=2: 2 + RB*(k+1).
  - k in {0,1}: 2.
- start while busy is ignored; no queueing. Inputs may change freely after acceptance.
- No intermediate product may exceed 2*DATA_WIDTH bits, because cand < 2^RB and saturated prod < 2^DATA_WIDTH.
- value=0 -> result 0. Value 2^DATA_WIDTH-1 must not wrap, which is guaranteed by the saturation rule.

Optional Feature:
- ROOT_EXACT_EN defined:
  - out_exact is initialised in INIT to (value==0) or (k==1).
  - It is set in CMP whenever a candidate is accepted with prod == value.
  - It is reported with output_ready and is 0 when error=1.
- ROOT_EXACT_EN undefined: the out_exact port is absent and no equality comparator is built.

Decomposition:
- Package root_operation_pkg holds:
  - the state enum (IDLE, INIT, SET_BIT, POW, CMP, DONE);
  - a function that computes RB from DATA_WIDTH.
- Sub-module root_power_step: the saturating multiply step (cand, prod, sat_in -> prod_next, sat_next). It is purely combinational and instantiated once inside POW.

Test Plan:
- Square root: k=2, value=1000000 -> out_value=1000, out_exact=1, error=0, output_ready exactly 50 cycles after start, busy high throughout.
- Cube root: k=3, value=30 -> out_value=3, out_exact=0; latency 66 cycles.
- Saturation: k=7, value=0xFFFFFFFF -> out_value=23 (24^7 overflows; no wrap), out_exact=0.
- Degenerate roots:
  - k=1, value=0xDEADBEEF -> out_value=0xDEADBEEF, out_exact=1, latency 2.
  - k=0 -> error=1, out_value=0, latency 2.
- Handshake: a second start pulse mid-search is ignored and the result matches the first request. Reset asserted at cycle 20 of a k=2 run -> all outputs 0 next cycle, no output_ready, and a fresh start completes normally.
- Zero input: k=5, value=0 -> out_value=0, out_exact=1.
